// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants and receiver state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
// Module : uart_receiver_if
// Brief  : Serial input, oversample tick and byte handshake of the UART receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_receiver_if;
  import uart_pkg::*;

  logic                      rx;
  logic                      clken;
  logic                      rdy_clr;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      rdy;
  logic                      frame_err;
  logic                      overrun;
  logic                      rx_busy;

  modport master (
    output rx, clken, rdy_clr,
    input  data_out, rdy, frame_err, overrun, rx_busy
  );

  modport slave (
    input  rx, clken, rdy_clr,
    output data_out, rdy, frame_err, overrun, rx_busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_sync_bit.sv
// ============================================================================
// Module : uart_sync_bit
// Brief  : Multi-flop synchroniser for an asynchronous bit; resets to 1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_sync_bit #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module : uart_receiver
// Brief  : 8N1 UART receiver, oversampled by a clock-enable tick, with
//          ready/clear handshake and framing/overrun flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic      clk_100m,
  input  wire logic      rst,
  uart_receiver_if.slave bus
);

  localparam int                  c_CNT_W   = $clog2(OVERSAMPLE);
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_MID = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
  localparam logic [2:0]          c_LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      w_rx_s;
  logic [2:0]                r_state;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [2:0]                r_bitpos;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] r_data_out;
  logic                      r_rdy;
  logic                      r_frame_err;
  logic                      r_overrun;

  uart_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk (clk_100m),
    .rst (rst),
    .i_d (bus.rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bitpos    <= '0;
      r_shreg     <= '0;
      r_data_out  <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Acknowledge first so that a byte completing this cycle overrides it.
      if (bus.rdy_clr) begin
        r_rdy     <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (bus.clken) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_rx_s) begin
              r_state <= RX_START;
              r_cnt   <= c_CNT_ONE;
            end
          end

          RX_START: begin
            if (r_cnt == c_CNT_MID) begin
              if (!w_rx_s) begin
                r_state  <= RX_DATA;
                r_cnt    <= '0;
                r_bitpos <= '0;
              end else begin
                r_state <= RX_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end

          RX_DATA: begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_CNT_MAX) begin
              r_shreg[r_bitpos] <= w_rx_s;
              if (r_bitpos == c_LAST_BIT) begin
                r_state <= RX_STOP;
              end else begin
                r_bitpos <= r_bitpos + 3'd1;
              end
            end
          end

          RX_STOP: begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (r_cnt == c_CNT_MAX) begin
              if (w_rx_s) begin
                r_data_out  <= r_shreg;
                r_rdy       <= 1'b1;
                r_frame_err <= 1'b0;
                r_overrun   <= r_rdy & ~bus.rdy_clr;
                r_state     <= RX_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= RX_BREAK;
              end
            end
          end

          // Wait for the line to return high so a held-low line cannot retrigger.
          RX_BREAK: begin
            if (w_rx_s) begin
              r_state <= RX_IDLE;
            end
          end

          default: begin
            r_state <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.rx_busy   = (r_state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module : tb_uart_receiver
// Brief  : Directed self-checking bench for uart_receiver (clken every 54 clocks).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   tick_idx;

  uart_receiver_if bus ();

  uart_receiver #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk_100m (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared baud generator: one clken pulse every 54 clocks; every 16th is the 1x tick.
  initial begin
    tick_idx  = 0;
    bus.clken = 1'b0;
    forever begin
      repeat (53) @(negedge clk);
      bus.clken = 1'b1;
      tick_idx  = tick_idx + 1;
      @(negedge clk);
      bus.clken = 1'b0;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (bus.clken !== 1'b1);
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    @(negedge clk);
    bus.rx = v;
    wait_ticks(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(b[i], 16);
    send_bit(stop_v, 16);
    @(negedge clk);
  endtask

  // Transmitter model: bit boundaries on the 1x tick of the shared generator.
  task automatic tx_send(input logic [7:0] b);
    do wait_ticks(1); while ((tick_idx % 16) != 0);
    send_byte(b, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
  endtask

  logic [7:0] lb [3];

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    lb[0] = 8'h00;
    lb[1] = 8'h81;
    lb[2] = 8'hFF;

    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(bus.data_out), 32'h00);
    check("reset_rdy", 32'(bus.rdy), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_overrun", 32'(bus.overrun), 32'h0);
    check("reset_rx_busy", 32'(bus.rx_busy), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_byte(8'hA5, 1'b1);
    check("a5_data_out", 32'(bus.data_out), 32'hA5);
    check("a5_rdy", 32'(bus.rdy), 32'h1);
    check("a5_frame_err", 32'(bus.frame_err), 32'h0);
    check("a5_overrun", 32'(bus.overrun), 32'h0);
    check("a5_rx_busy", 32'(bus.rx_busy), 32'h0);
    pulse_clr();
    check("a5_clr_rdy", 32'(bus.rdy), 32'h0);

    // Start-bit glitch of 4 ticks.
    send_bit(1'b0, 4);
    check("glitch_busy_during", 32'(bus.rx_busy), 32'h1);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("glitch_busy_after", 32'(bus.rx_busy), 32'h0);
    check("glitch_rdy", 32'(bus.rdy), 32'h0);
    check("glitch_frame_err", 32'(bus.frame_err), 32'h0);
    check("glitch_data_out", 32'(bus.data_out), 32'hA5);

    // Low stop bit, line then held low.
    send_byte(8'h3C, 1'b0);
    check("ferr_frame_err", 32'(bus.frame_err), 32'h1);
    check("ferr_rdy", 32'(bus.rdy), 32'h0);
    check("ferr_data_out", 32'(bus.data_out), 32'hA5);
    check("ferr_busy", 32'(bus.rx_busy), 32'h1);
    send_bit(1'b0, 24);
    @(negedge clk);
    check("break_busy_held", 32'(bus.rx_busy), 32'h1);
    send_bit(1'b1, 4);
    @(negedge clk);
    check("break_busy_release", 32'(bus.rx_busy), 32'h0);

    send_byte(8'h55, 1'b1);
    check("55_data_out", 32'(bus.data_out), 32'h55);
    check("55_frame_err", 32'(bus.frame_err), 32'h0);
    check("55_rdy", 32'(bus.rdy), 32'h1);
    pulse_clr();

    send_byte(8'h11, 1'b1);
    check("11_data_out", 32'(bus.data_out), 32'h11);
    check("11_overrun", 32'(bus.overrun), 32'h0);
    send_byte(8'h22, 1'b1);
    check("22_data_out", 32'(bus.data_out), 32'h22);
    check("22_rdy", 32'(bus.rdy), 32'h1);
    check("22_overrun", 32'(bus.overrun), 32'h1);
    pulse_clr();
    check("ovr_clr_rdy", 32'(bus.rdy), 32'h0);
    check("ovr_clr_overrun", 32'(bus.overrun), 32'h0);

    // Frame of 0x99 abandoned by reset halfway through data bit 3.
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    @(negedge clk);
    check("rst_busy_before", 32'(bus.rx_busy), 32'h1);
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    check("rst_mid_data_out", 32'(bus.data_out), 32'h00);
    check("rst_mid_rdy", 32'(bus.rdy), 32'h0);
    check("rst_mid_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_mid_overrun", 32'(bus.overrun), 32'h0);
    check("rst_mid_busy", 32'(bus.rx_busy), 32'h0);
    rst = 1'b0;
    send_bit(1'b1, 16);

    send_byte(8'hF0, 1'b1);
    check("f0_data_out", 32'(bus.data_out), 32'hF0);
    check("f0_rdy", 32'(bus.rdy), 32'h1);
    pulse_clr();

    for (int k = 0; k < 3; k++) begin
      tx_send(lb[k]);
      check($sformatf("loop%0d_data_out", k), 32'(bus.data_out), 32'(lb[k]));
      check($sformatf("loop%0d_frame_err", k), 32'(bus.frame_err), 32'h0);
      check($sformatf("loop%0d_rdy", k), 32'(bus.rdy), 32'h1);
      pulse_clr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
